// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the sized data memory.
// Lanes are big-endian: byte offset 0 lives in bits [31:24].
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } rsp_stage_t;

  // Bit position of the addressed lane's LSB within the word.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return {~off, 3'b000};
      SZ_HALF: return {~off[1], 4'b0000};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 32'h0000_00ff;
      SZ_HALF: return 32'h0000_ffff;
      SZ_WORD: return 32'hffff_ffff;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [4:0]  sh;
    logic [31:0] m;
    sh = lane_shift(size, off);
    m  = lane_mask(size);
    return (old_word & ~(m << sh)) | ((wdata & m) << sh);
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        is_unsigned);
    logic [31:0] v;
    v = (word >> lane_shift(size, off)) & lane_mask(size);
    if (!is_unsigned) begin
      case (size)
        SZ_BYTE: v = {{24{v[7]}}, v[7:0]};
        SZ_HALF: v = {{16{v[15]}}, v[15:0]};
        default: v = v;
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/dmem_sized_pipe_if.sv
// Request/response bus between the load/store unit (master) and the data memory (slave).
interface dmem_sized_pipe_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_rsp_pipe.sv
// READ_LAT-deep response shift register; a single stall freezes every stage.
module dmem_rsp_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       stall,
  input  rsp_stage_t in_stage,
  output rsp_stage_t out_stage,
  output logic       any_valid
);

  logic [READ_LAT-1:0] valid_vec;

  for (genvar g = 0; g < READ_LAT; g++) begin : g_stage
    rsp_stage_t q;
    rsp_stage_t d;

    if (g == 0) begin : g_head
      assign d = in_stage;
    end else begin : g_tail
      assign d = g_stage[g-1].q;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        q <= '0;
      end else if (!stall) begin
        q <= d;
      end
    end

    assign valid_vec[g] = q.valid;
  end

  assign out_stage = g_stage[READ_LAT-1].q;
  assign any_valid = |valid_vec;

endmodule

// File: rtl/dmem_sized_pipe.sv
// Sized big-endian data memory with range/alignment errors and a valid/ready response pipe.
// Define DMEM_TRACE_EN to print committed stores and errored requests.
module dmem_sized_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 262144,
  parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
  parameter int unsigned READ_LAT    = 1
) (
  input logic               clock,
  input logic               reset,
  dmem_sized_pipe_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [31:0]     word_off;
  logic [IdxW-1:0] idx;
  logic            out_of_range;
  logic            size_bad;
  logic            misalign;
  logic            req_err;
  logic            stall;
  logic            accept;
  logic            wr_en;
  logic            any_valid;
  rsp_stage_t      in_stage;
  rsp_stage_t      out_stage;

  always_comb begin
    // Unsigned wrap makes addresses below BASE_ADDR look huge; the explicit compare covers it too.
    word_off     = (bus.req_addr - BASE_ADDR) >> 2;
    idx          = word_off[IdxW-1:0];
    out_of_range = (bus.req_addr < BASE_ADDR) || (word_off >= DEPTH_WORDS);
    size_bad     = (bus.req_size == SZ_BAD);
    misalign     = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                   ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
    req_err      = out_of_range || size_bad || misalign;

    stall        = out_stage.valid && !bus.rsp_ready;
    bus.req_ready = !reset && !stall;
    accept       = bus.req_valid && bus.req_ready;
    wr_en        = accept && bus.req_write && !req_err;

    in_stage.valid = accept;
    in_stage.err   = accept && req_err;
    in_stage.rdata = '0;
    if (accept && !bus.req_write && !req_err) begin
      in_stage.rdata = lane_extract(mem_q[idx], bus.req_size, bus.req_addr[1:0],
                                    bus.req_unsigned);
    end
  end

  // Store commits at the accept edge, so a load on the next cycle sees it.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[idx] <= lane_merge(mem_q[idx], bus.req_wdata, bus.req_size, bus.req_addr[1:0]);
    end
  end

  dmem_rsp_pipe #(
    .READ_LAT (READ_LAT)
  ) u_rsp_pipe (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .in_stage  (in_stage),
    .out_stage (out_stage),
    .any_valid (any_valid)
  );

  assign bus.rsp_valid = out_stage.valid;
  assign bus.rsp_err   = out_stage.err;
  assign bus.rsp_rdata = out_stage.rdata;
  assign bus.busy      = any_valid;

`ifdef DMEM_TRACE_EN
  always_ff @(posedge clock) begin
    if (wr_en) begin
      $display("%0t dmem store addr=%h idx=%0d word=%h", $time, bus.req_addr, idx,
               lane_merge(mem_q[idx], bus.req_wdata, bus.req_size, bus.req_addr[1:0]));
    end
    if (accept && req_err) begin
      $display("%0t dmem error addr=%h cause=%s", $time, bus.req_addr,
               out_of_range ? "range" : (size_bad ? "size" : "align"));
    end
  end
`endif

endmodule

// File: tb/tb_dmem_sized_pipe.sv
// Bench for dmem_sized_pipe: directed vector table, stall/reset sequences, random traffic
// against a byte-array model, and a READ_LAT 1..4 latency/throughput sweep.
module tb_dmem_sized_pipe;
  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_sized_pipe_if mif ();

  dmem_sized_pipe #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .READ_LAT    (LAT)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (mif)
  );

  // Latency sweep instances share one stimulus.
  logic        sw_valid = 1'b0;
  logic        sw_write = 1'b0;
  logic [31:0] sw_addr  = BASE;
  logic [31:0] sw_wdata = '0;

  for (genvar g = 1; g <= 4; g++) begin : g_sw
    dmem_sized_pipe_if sif ();
    assign sif.req_valid    = sw_valid;
    assign sif.req_write    = sw_write;
    assign sif.req_size     = 2'b10;
    assign sif.req_unsigned = 1'b0;
    assign sif.req_addr     = sw_addr;
    assign sif.req_wdata    = sw_wdata;
    assign sif.rsp_ready    = 1'b1;
    dmem_sized_pipe #(
      .DEPTH_WORDS (16),
      .BASE_ADDR   (BASE),
      .READ_LAT    (g)
    ) u_sw (
      .clock (clock),
      .reset (reset),
      .bus   (sif)
    );
  end

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(act === exp, name, act, exp);
  endtask

  // ---------------- reference model: big-endian byte array ----------------
  logic [7:0] mb [4*DEPTH];
  bit         kn [4*DEPTH];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk;
    int          acc;
  } exp_t;

  function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] d, output exp_t e);
    logic [31:0] off;
    logic [31:0] v;
    int nb;
    off = a - BASE;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    e.rdata = '0;
    e.chk = 1'b1;
    e.acc = 0;
    e.err = (a < BASE) || ((off / 4) >= DEPTH) || (nb == 0);
    if (!e.err && (a % nb) != 0) e.err = 1'b1;
    if (e.err) return;
    if (w) begin
      for (int k = 0; k < nb; k++) begin
        mb[off + k] = 8'(d >> (8 * (nb - 1 - k)));
        kn[off + k] = 1'b1;
      end
    end else begin
      v = '0;
      for (int k = 0; k < nb; k++) begin
        v = (v << 8) | 32'(mb[off + k]);
        if (!kn[off + k]) e.chk = 1'b0;
      end
      if (!u && v[8 * nb - 1]) v = v | (32'hffff_ffff << (8 * nb));
      e.rdata = v;
    end
  endfunction

  // ---------------- scoreboard monitor ----------------
  exp_t        exp_q[$];
  bit          chk_lat = 1'b0;
  int          rsp_cnt = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  bit          have_prev = 1'b0;
  logic [31:0] prev_rdata;
  logic        prev_err;

  always @(negedge clock) begin
    exp_t e;
    #2;
    if (reset) begin
      exp_q.delete();
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        check(mif.rsp_valid && mif.rsp_rdata === prev_rdata && mif.rsp_err === prev_err,
              "rsp_stable", mif.rsp_rdata, prev_rdata);
      end
      have_prev  = mif.rsp_valid && !mif.rsp_ready;
      prev_rdata = mif.rsp_rdata;
      prev_err   = mif.rsp_err;
      if (mif.rsp_valid && mif.rsp_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "rsp_unexpected", mif.rsp_rdata, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk_eq("rsp_err", 32'(mif.rsp_err), 32'(e.err));
          if (e.chk) chk_eq("rsp_rdata", mif.rsp_rdata, e.rdata);
          if (chk_lat) chk_eq("rsp_latency", 32'(cyc - e.acc), 32'(LAT));
        end
        last_rdata = mif.rsp_rdata;
        last_err   = mif.rsp_err;
        rsp_cnt++;
      end
      if (mif.req_valid && mif.req_ready) begin
        model(mif.req_write, mif.req_size, mif.req_unsigned, mif.req_addr, mif.req_wdata, e);
        e.acc = cyc;
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic idle();
    mif.req_valid = 1'b0;
    mif.req_write = 1'b0;
    mif.req_size = 2'b10;
    mif.req_unsigned = 1'b0;
    mif.req_addr = BASE;
    mif.req_wdata = '0;
  endtask

  task automatic send(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
    int t = 0;
    @(negedge clock);
    mif.req_valid = 1'b1;
    mif.req_write = w;
    mif.req_size = sz;
    mif.req_unsigned = u;
    mif.req_addr = a;
    mif.req_wdata = d;
    #1;
    while (!mif.req_ready && t < 50) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (!mif.req_ready) check(1'b0, "accept_timeout", 32'h0, 32'h1);
    @(posedge clock);
  endtask

  // One request, then wait for its response and compare with table constants.
  task automatic xact(input string name, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d, input logic err,
                      input logic [31:0] r);
    int cnt0 = rsp_cnt;
    bit got = 1'b0;
    send(w, sz, u, a, d);
    for (int t = 0; t < 20; t++) begin
      @(negedge clock);
      mif.req_valid = 1'b0;
      #3;
      if (rsp_cnt != cnt0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check(1'b0, {name, "_timeout"}, 32'h0, 32'h1);
    end else begin
      chk_eq({name, "_err"}, 32'(last_err), 32'(err));
      chk_eq({name, "_rdata"}, last_rdata, r);
    end
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] d;
    logic        err;
    logic [31:0] r;
  } vec_t;

  logic [31:0] sw_data [4];
  int          sw_cnt  [5];

  task automatic sw_sample(input int lat, input logic v, input logic [31:0] r,
                           input logic e, input int t);
    int k;
    logic [31:0] want;
    if (!v) return;
    k = t - lat;
    want = (k >= 4 && k < 8) ? sw_data[k - 4] : 32'h0;
    check(k >= 0 && k < 8 && r === want && !e, $sformatf("sweep_lat%0d_rsp", lat), r, want);
    sw_cnt[lat]++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int cnt0;
    int spurious;
    bit rdy_ok;

    idle();
    mif.rsp_ready = 1'b1;

    // ---- reset state ----
    repeat (3) @(negedge clock);
    #3;
    chk_eq("reset_req_ready", 32'(mif.req_ready), 32'h0);
    chk_eq("reset_rsp_valid", 32'(mif.rsp_valid), 32'h0);
    chk_eq("reset_busy", 32'(mif.busy), 32'h0);
    chk_eq("reset_rsp_rdata", mif.rsp_rdata, 32'h0);
    chk_eq("reset_rsp_err", 32'(mif.rsp_err), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #3;
    chk_eq("post_reset_req_ready", 32'(mif.req_ready), 32'h1);

    // ---- directed vector table ----
    tbl.push_back('{"st_w",     1, 2'd2, 0, BASE,         32'hDEAD_BEEF, 0, 32'h0});
    tbl.push_back('{"ld_w",     0, 2'd2, 0, BASE,         32'h0,         0, 32'hDEAD_BEEF});
    tbl.push_back('{"st_b",     1, 2'd0, 0, BASE + 1,     32'h0000_005A, 0, 32'h0});
    tbl.push_back('{"ld_bu",    0, 2'd0, 1, BASE + 1,     32'h0,         0, 32'h0000_005A});
    tbl.push_back('{"ld_bs",    0, 2'd0, 0, BASE + 1,     32'h0,         0, 32'h0000_005A});
    tbl.push_back('{"ld_w2",    0, 2'd2, 0, BASE,         32'h0,         0, 32'hDE5A_BEEF});
    tbl.push_back('{"st_b80",   1, 2'd0, 0, BASE + 3,     32'h0000_0080, 0, 32'h0});
    tbl.push_back('{"ld_bs80",  0, 2'd0, 0, BASE + 3,     32'h0,         0, 32'hFFFF_FF80});
    tbl.push_back('{"ld_h_mis", 0, 2'd1, 0, BASE + 1,     32'h0,         1, 32'h0});
    tbl.push_back('{"st_w_mis", 1, 2'd2, 0, BASE + 2,     32'h1234_5678, 1, 32'h0});
    tbl.push_back('{"ld_low",   0, 2'd2, 0, BASE - 4,     32'h0,         1, 32'h0});
    tbl.push_back('{"ld_high",  0, 2'd2, 0, BASE + 4 * DEPTH, 32'h0,     1, 32'h0});
    tbl.push_back('{"st_ill",   1, 2'd3, 0, BASE,         32'h0,         1, 32'h0});
    tbl.push_back('{"ld_w3",    0, 2'd2, 0, BASE,         32'h0,         0, 32'hDE5A_BE80});
    tbl.push_back('{"ld_ill",   0, 2'd3, 0, BASE,         32'h0,         1, 32'h0});
    tbl.push_back('{"ld_hs",    0, 2'd1, 0, BASE + 2,     32'h0,         0, 32'hFFFF_BE80});
    tbl.push_back('{"ld_hu",    0, 2'd1, 1, BASE,         32'h0,         0, 32'h0000_DE5A});
    tbl.push_back('{"st_h",     1, 2'd1, 0, BASE + 6,     32'h0000_A1B2, 0, 32'h0});
    tbl.push_back('{"ld_hs6",   0, 2'd1, 0, BASE + 6,     32'h0,         0, 32'hFFFF_A1B2});
    tbl.push_back('{"st_last",  1, 2'd2, 0, BASE + 4 * (DEPTH - 1), 32'h1357_9BDF, 0, 32'h0});
    tbl.push_back('{"ld_last",  0, 2'd2, 0, BASE + 4 * (DEPTH - 1), 32'h0, 0, 32'h1357_9BDF});
    chk_lat = 1'b1;
    foreach (tbl[i]) begin
      xact(tbl[i].name, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].d, tbl[i].err,
           tbl[i].r);
    end
    chk_lat = 1'b0;

    // ---- 8 back-to-back requests with a 3-cycle response stall ----
    cnt0 = rsp_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(i[0], 2'd2, 1'b0, BASE + 4 * (i / 2), 32'hC0DE_0000 + i);
        end
        @(negedge clock);
        mif.req_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clock);
          mif.rsp_ready = 1'b0;
          #1;
          check(!mif.req_ready && mif.rsp_valid, "stall_req_ready", 32'(mif.req_ready), 32'h0);
        end
        @(negedge clock);
        mif.rsp_ready = 1'b1;
      end
    join
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clock);
    #3;
    chk_eq("stall_rsp_count", 32'(rsp_cnt - cnt0), 32'd8);
    chk_eq("stall_queue_empty", 32'(exp_q.size()), 32'h0);

    // ---- random traffic ----
    for (int w = 0; w < 16; w++) send(1'b1, 2'd2, 1'b0, BASE + 4 * w, $urandom);
    for (int n = 0; n < 400; n++) begin
      int r;
      @(negedge clock);
      r = int'($urandom_range(0, 9));
      mif.req_valid = ($urandom_range(0, 3) != 0);
      mif.req_write = $urandom_range(0, 1) != 0;
      mif.req_size = 2'($urandom_range(0, 3));
      mif.req_unsigned = $urandom_range(0, 1) != 0;
      mif.req_wdata = $urandom;
      if (r < 8) mif.req_addr = BASE + $urandom_range(0, 63);
      else if (r == 8) mif.req_addr = BASE - 8 + $urandom_range(0, 7);
      else mif.req_addr = BASE + 4 * DEPTH - 4 + $urandom_range(0, 7);
      mif.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clock);
    idle();
    mif.rsp_ready = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clock);
    #3;
    chk_eq("random_queue_empty", 32'(exp_q.size()), 32'h0);

    // ---- reset with two requests in flight ----
    send(1'b1, 2'd2, 1'b0, BASE + 20, 32'h0BAD_F00D);
    send(1'b0, 2'd2, 1'b0, BASE, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    mif.req_valid = 1'b1;
    mif.req_write = 1'b1;
    mif.req_addr = BASE + 20;
    mif.req_wdata = 32'hFFFF_FFFF;
    #1;
    chk_eq("rst_req_ready", 32'(mif.req_ready), 32'h0);
    @(negedge clock);
    #1;
    chk_eq("rst_busy", 32'(mif.busy), 32'h0);
    chk_eq("rst_rsp_valid", 32'(mif.rsp_valid), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    idle();
    spurious = 0;
    for (int t = 0; t < 6; t++) begin
      #3;
      if (mif.rsp_valid) spurious++;
      @(negedge clock);
    end
    chk_eq("rst_no_stale_rsp", 32'(spurious), 32'h0);
    chk_lat = 1'b1;
    xact("rst_store_kept", 1'b0, 2'd2, 1'b0, BASE + 20, 32'h0, 1'b0, 32'h0BAD_F00D);
    chk_lat = 1'b0;

    // ---- READ_LAT sweep: 4 stores then 4 loads back to back ----
    for (int k = 0; k < 4; k++) sw_data[k] = $urandom;
    for (int l = 0; l < 5; l++) sw_cnt[l] = 0;
    rdy_ok = 1'b1;
    for (int t = 0; t < 16; t++) begin
      @(negedge clock);
      sw_valid = (t < 8);
      sw_write = (t < 4);
      sw_addr = BASE + 4 * (t % 4);
      sw_wdata = sw_data[t % 4];
      #2;
      if (t < 8) begin
        rdy_ok &= g_sw[1].sif.req_ready && g_sw[2].sif.req_ready &&
                  g_sw[3].sif.req_ready && g_sw[4].sif.req_ready;
      end
      sw_sample(1, g_sw[1].sif.rsp_valid, g_sw[1].sif.rsp_rdata, g_sw[1].sif.rsp_err, t);
      sw_sample(2, g_sw[2].sif.rsp_valid, g_sw[2].sif.rsp_rdata, g_sw[2].sif.rsp_err, t);
      sw_sample(3, g_sw[3].sif.rsp_valid, g_sw[3].sif.rsp_rdata, g_sw[3].sif.rsp_err, t);
      sw_sample(4, g_sw[4].sif.rsp_valid, g_sw[4].sif.rsp_rdata, g_sw[4].sif.rsp_err, t);
    end
    chk_eq("sweep_req_ready", 32'(rdy_ok), 32'h1);
    for (int l = 1; l <= 4; l++) begin
      chk_eq($sformatf("sweep_lat%0d_count", l), 32'(sw_cnt[l]), 32'd8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
